clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
Parametrised multi-channel programmable clock divider. Generates NUM_CH independent divided clocks from one input clock, each with its own runtime-loadable divisor, enable and period-start tick strobe. Divisor changes are glitch-free: a new divisor takes effect only at a period boundary. It serves the audio/tone and LED-rate generators that previously each used a fixed single-channel divider.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 28, counter and divisor width in bits
RST_DIV, 2, divisor loaded into every channel at reset

Ports:
clock_in  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  NUM_CH  per-channel run enable
load  input  NUM_CH  per-channel 1-cycle strobe; captures that channel's divisor slice
divisor_in  input  NUM_CH*CNT_W  packed divisors; channel i at [i*CNT_W +: CNT_W]
clock_out  output  NUM_CH  registered divided clocks
tick  output  NUM_CH  registered 1-cycle pulse at the start of each period
busy  output  NUM_CH  channel in RUN state

Behaviour:
- Per channel: active divisor N_act, pending divisor N_pend, counter cnt, and state IDLE/RUN.
- Reset (async, reset_n=0): clock_out=0, tick=0, busy=0, cnt=0, N_act=N_pend=RST_DIV, state=IDLE.
- Load: when load[i]=1 at an edge, N_pend<=divisor_in slice. If load arrives in IDLE, it also takes effect at the next period start. Otherwise it never disturbs the period in progress.
- Period: N input cycles. High length H=N-(N>>1), low length N>>1. Odd N gives the extra cycle high; for example, N=5 is 3 high and 2 low.
- IDLE with enable=1 at an edge (period start):
  - N_act<=N_pend, cnt<=1.
  - tick<=1, clock_out<=1, state<=RUN.
  - The first high appears 1 cycle after enable is sampled.
- RUN with enable=1:
  - If cnt==N_act: period start as above. This is the wrap boundary and the only point where N_pend is adopted.
  - Otherwise: cnt<=cnt+1, tick<=0, clock_out<=(cnt<H_act).
- Enable deasserted at any edge: state<=IDLE, cnt<=0, clock_out<=0, tick<=0. The next enable restarts cleanly with a full high phase.
- Degenerate divisors, evaluated on N_act:
  - N=0: channel stopped. clock_out=0 and tick=0, but busy=1 while enabled. A new load is adopted on the next edge, because N=0 counts as at a boundary.
  - N=1: clock_out held 1 and tick=1 every cycle.
- Load and boundary on the same edge: the boundary adopts the old N_pend, and the new value lands in N_pend for the following boundary.
- Width: cnt and compare are CNT_W bits with no overflow. Max N=2^CNT_W-1.
- Channels are fully independent, with no shared state.

Optional Feature:
DUTY_CTRL_EN
- Defined: adds input high_in (NUM_CH*CNT_W), captured into a pending high length together with load. At the boundary, H_act<=clamp(high_in, 1, N-1) for N>=2.
- Undefined: the port is absent and H follows the 50% rule above.

Decomposition:
- Package clk_div_pkg: state enum (ST_IDLE, ST_RUN), default CNT_W, RST_DIV constant, and the half-length function used for H.
- Sub-module clk_div_channel: one channel's counter, registers and FSM. The top only slices buses and generates NUM_CH instances.

Test Plan:
1. Reset, load ch0 N=4, enable ch0 -> clock_out high 2 / low 2 repeating; tick every 4 cycles, coincident with each rising edge of clock_out.
2. Ch1 N=5 enabled -> high 3 / low 2, period 5; ch0 (N=4) is unaffected when run concurrently.
3. Ch0 running N=4; load N=8 at cnt=2 -> current period completes at 4 cycles, then the 8-cycle period (4H/4L) starts with a tick.
4. Drop enable mid-high -> next edge clock_out=0, busy=0. Re-enable -> high 1 cycle later for a full H.
5. Assert reset_n=0 mid-period -> all outputs 0 immediately, without a clock. On release, N_act=RST_DIV=2.
6. N=1 -> clock_out constant 1, tick every cycle. N=0 -> clock_out=0, tick=0, busy=1. With DUTY_CTRL_EN, N=10 and high_in=3 -> 3H/7L; high_in=0 clamps to 1H/9L.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional macro DUTY_CTRL_EN (used by clk_div_channel/clk_div_multi) adds programmable high length.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ch_state_e;

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_CNT_W   = 28;
  localparam int unsigned DEF_RST_DIV = 2;

  // High length for the 50% rule: odd divisors put the extra cycle in the high phase.
  function automatic logic [31:0] half_len(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor and IDLE/RUN FSM.
// Macro DUTY_CTRL_EN adds a pending/active high length loaded from high_in.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
`ifdef DUTY_CTRL_EN
  input  logic [CNT_W-1:0] high_in,
`endif
  input  logic [CNT_W-1:0] divisor_in,
  output logic             clock_out,
  output logic             tick,
  output logic             busy
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic [CNT_W-1:0] n_pend_q, n_pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] h_act;
  logic             boundary;

`ifdef DUTY_CTRL_EN
  logic [CNT_W-1:0] h_pend_q, h_pend_d;
  logic [CNT_W-1:0] h_act_q, h_act_d;

  function automatic logic [CNT_W-1:0] clamp_h(input logic [CNT_W-1:0] h,
                                               input logic [CNT_W-1:0] n);
    if (n < CNT_W'(2)) return CNT_W'(1);
    if (h == '0) return CNT_W'(1);
    if (h > n - CNT_W'(1)) return n - CNT_W'(1);
    return h;
  endfunction

  assign h_act = h_act_q;
`else
  assign h_act = CNT_W'(half_len(32'(n_act_q)));
`endif

  // A stopped channel (N=0) sits permanently at a boundary so a new load is adopted at once.
  assign boundary = (state_q == ST_IDLE) || (cnt_q == n_act_q) || (n_act_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_act_d  = n_act_q;
    n_pend_d = load ? divisor_in : n_pend_q;
    clk_d    = clk_q;
    tick_d   = tick_q;
`ifdef DUTY_CTRL_EN
    h_pend_d = load ? high_in : h_pend_q;
    h_act_d  = h_act_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
    end else if (boundary) begin
      state_d = ST_RUN;
      n_act_d = n_pend_q;
      cnt_d   = CNT_W'(1);
      clk_d   = (n_pend_q != '0);
      tick_d  = (n_pend_q != '0);
`ifdef DUTY_CTRL_EN
      h_act_d = clamp_h(h_pend_q, n_pend_q);
`endif
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      clk_d  = (cnt_q < h_act);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      n_act_q  <= CNT_W'(RST_DIV);
      n_pend_q <= CNT_W'(RST_DIV);
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
`ifdef DUTY_CTRL_EN
      h_pend_q <= CNT_W'(half_len(32'(RST_DIV)));
      h_act_q  <= CNT_W'(half_len(32'(RST_DIV)));
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_act_q  <= n_act_d;
      n_pend_q <= n_pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
`ifdef DUTY_CTRL_EN
      h_pend_q <= h_pend_d;
      h_act_q  <= h_act_d;
`endif
    end
  end

  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one input clock.
// Macro DUTY_CTRL_EN adds the high_in bus for per-channel high length.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       load,
`ifdef DUTY_CTRL_EN
  input  logic [NUM_CH*CNT_W-1:0] high_in,
`endif
  input  logic [NUM_CH*CNT_W-1:0] divisor_in,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W  (CNT_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable[g]),
      .load      (load[g]),
`ifdef DUTY_CTRL_EN
      .high_in   (high_in[g*CNT_W +: CNT_W]),
`endif
      .divisor_in(divisor_in[g*CNT_W +: CNT_W]),
      .clock_out (clock_out[g]),
      .tick      (tick[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: vector table plus hand sequences, expected outputs via scoreboard queue.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;

  logic                    clock_in;
  logic                    reset_n;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] divisor_in;
  logic [NUM_CH-1:0]       clock_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       busy;
`ifdef DUTY_CTRL_EN
  logic [NUM_CH*CNT_W-1:0] high_in;
  logic                    hi_ovr;
  logic [7:0]              hi_val;
`endif

  clk_div_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .RST_DIV(2)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
`ifdef DUTY_CTRL_EN
    .high_in   (high_in),
`endif
    .divisor_in(divisor_in),
    .clock_out (clock_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [3:0] en;
    logic [3:0] ld;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] clk;
    logic [3:0] tck;
    logic [3:0] bsy;
  } vec_t;

  typedef struct {
    logic [3:0] clk;
    logic [3:0] tck;
    logic [3:0] bsy;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;
  string phase = "reset";

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s step %0d: got %b expected %b", phase, name, step_no, got, exp);
    end
  endtask

  function automatic void add(input logic [3:0] en, input logic [3:0] ld, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [3:0] c, input logic [3:0] t,
                              input logic [3:0] b);
    vec_t v;
    v.en = en; v.ld = ld; v.d0 = d0; v.d1 = d1; v.clk = c; v.tck = t; v.bsy = b;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic [3:0] en, input logic [3:0] ld, input logic [7:0] d0,
                      input logic [7:0] d1, input logic [3:0] c, input logic [3:0] t,
                      input logic [3:0] b);
    exp_t e;
    @(negedge clock_in);
    enable     = en;
    load       = ld;
    divisor_in = {16'h0, d1, d0};
`ifdef DUTY_CTRL_EN
    high_in = {16'h0, d1 - (d1 >> 1), hi_ovr ? hi_val : d0 - (d0 >> 1)};
`endif
    e.clk = c; e.tck = t; e.bsy = b;
    sb.push_back(e);
    @(posedge clock_in);
    #1;
    e = sb.pop_front();
    check4("clock_out", clock_out, e.clk);
    check4("tick", tick, e.tck);
    check4("busy", busy, e.bsy);
    step_no++;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = '0;
    load       = '0;
    divisor_in = '0;
`ifdef DUTY_CTRL_EN
    high_in = '0;
    hi_ovr  = 1'b0;
    hi_val  = '0;
`endif
    #12;
    check4("rst_clock_out", clock_out, 4'h0);
    check4("rst_tick", tick, 4'h0);
    check4("rst_busy", busy, 4'h0);
    reset_n = 1'b1;

    // ch0 N=4, ch1 N=5 concurrently; ch0 reloaded to 8 mid-period, dropped, restarted,
    // then reloaded to 3 on a boundary edge.
    add(4'h0, 4'h3, 8'd4, 8'd5, 4'h0, 4'h0, 4'h0);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h3, 4'h3, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h3, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h0, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h1, 4'h1, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h3, 4'h2, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h1, 4'h1, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h1, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h2, 4'h2, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h3, 4'h1, 4'h3);
    add(4'h3, 4'h0, 8'd4, 8'd5, 4'h1, 4'h0, 4'h3);
    add(4'h3, 4'h1, 8'd8, 8'd5, 4'h0, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h2, 4'h2, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h3, 4'h1, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h3, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h1, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h1, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h2, 4'h2, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h2, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h0, 4'h0, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h1, 4'h1, 4'h3);
    add(4'h3, 4'h0, 8'd8, 8'd5, 4'h3, 4'h2, 4'h3);
    add(4'h0, 4'h0, 8'd8, 8'd5, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h0, 8'd8, 8'd5, 4'h1, 4'h1, 4'h1);
    for (int i = 0; i < 3; i++) add(4'h1, 4'h0, 8'd8, 8'd5, 4'h1, 4'h0, 4'h1);
    for (int i = 0; i < 4; i++) add(4'h1, 4'h0, 8'd8, 8'd5, 4'h0, 4'h0, 4'h1);
    add(4'h1, 4'h1, 8'd3, 8'd5, 4'h1, 4'h1, 4'h1);
    for (int i = 0; i < 3; i++) add(4'h1, 4'h0, 8'd3, 8'd5, 4'h1, 4'h0, 4'h1);
    for (int i = 0; i < 4; i++) add(4'h1, 4'h0, 8'd3, 8'd5, 4'h0, 4'h0, 4'h1);
    add(4'h1, 4'h0, 8'd3, 8'd5, 4'h1, 4'h1, 4'h1);
    add(4'h1, 4'h0, 8'd3, 8'd5, 4'h1, 4'h0, 4'h1);
    add(4'h1, 4'h0, 8'd3, 8'd5, 4'h0, 4'h0, 4'h1);
    add(4'h1, 4'h0, 8'd3, 8'd5, 4'h1, 4'h1, 4'h1);

    phase = "table";
    foreach (vecs[i])
      step(vecs[i].en, vecs[i].ld, vecs[i].d0, vecs[i].d1, vecs[i].clk, vecs[i].tck, vecs[i].bsy);

    // Asynchronous reset mid-period: outputs clear without a clock edge.
    phase = "async_reset";
    #2;
    reset_n = 1'b0;
    enable  = '0;
    #1;
    check4("clock_out", clock_out, 4'h0);
    check4("tick", tick, 4'h0);
    check4("busy", busy, 4'h0);
    #3;
    reset_n = 1'b1;
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h1, 4'h1, 4'h1);
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h1, 4'h1, 4'h1);
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h1);

    phase = "n1_n0";
    step(4'h0, 4'h1, 8'd1, 8'd0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h1, 4'h0, 8'd1, 8'd0, 4'h1, 4'h1, 4'h1);
    step(4'h1, 4'h1, 8'd0, 8'd0, 4'h1, 4'h1, 4'h1);
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h1, 8'd2, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd2, 8'd0, 4'h1, 4'h1, 4'h1);
    step(4'h1, 4'h0, 8'd2, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd2, 8'd0, 4'h1, 4'h1, 4'h1);

`ifdef DUTY_CTRL_EN
    phase  = "duty_3";
    hi_ovr = 1'b1;
    hi_val = 8'd3;
    step(4'h0, 4'h1, 8'd10, 8'd0, 4'h0, 4'h0, 4'h0);
    step(4'h1, 4'h0, 8'd10, 8'd0, 4'h1, 4'h1, 4'h1);
    for (int i = 0; i < 2; i++) step(4'h1, 4'h0, 8'd10, 8'd0, 4'h1, 4'h0, 4'h1);
    for (int i = 0; i < 7; i++) step(4'h1, 4'h0, 8'd10, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd10, 8'd0, 4'h1, 4'h1, 4'h1);
    phase  = "duty_0";
    hi_val = 8'd0;
    step(4'h0, 4'h1, 8'd10, 8'd0, 4'h0, 4'h0, 4'h0);
    step(4'h1, 4'h0, 8'd10, 8'd0, 4'h1, 4'h1, 4'h1);
    for (int i = 0; i < 9; i++) step(4'h1, 4'h0, 8'd10, 8'd0, 4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h0, 8'd10, 8'd0, 4'h1, 4'h1, 4'h1);
    hi_ovr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
